// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit controller with architectural HI/LO.
//   clk, rst          : clock, async active-high reset
//   start, func, sign : EX-stage request (MUL/DIV), signedness
//   src_a, src_b      : operands (multiplicand/dividend, multiplier/divisor)
//   flush             : abort the operation in flight
//   hi_write/_data    : MTHI
//   lo_write/_data    : MTLO
//   stall             : hold the pipeline while the unit is working
//   hi, lo            : architectural registers
//   busy              : unit is not idle
// MUL takes one compute cycle; DIV is a 32-cycle restoring divide on
// magnitudes with sign fix-up applied in DONE; divide by zero skips to DONE.
module mdu_ctrl #(
  parameter logic [4:0] FUNC_MUL = 5'h18,
  parameter logic [4:0] FUNC_DIV = 5'h1A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  func,
  input  logic        sign,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  input  logic        hi_write,
  input  logic [31:0] hi_write_data,
  input  logic        lo_write,
  input  logic [31:0] lo_write_data,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  // Captured request
  typedef struct packed {
    logic [31:0] a;      // raw src_a
    logic [31:0] b;      // raw src_b
    logic        sgn;
    logic        is_div;
    logic        div0;
    logic        neg_q;  // quotient needs negation
    logic        neg_r;  // remainder needs negation
  } req_t;

  state_t      state;
  req_t        req;
  logic [5:0]  cnt;
  logic [31:0] rem_r, quot_r;
  logic [63:0] prod_r;
  logic [31:0] hi_r, lo_r;

  logic        mul_req, div_req, accept;
  logic [31:0] a_mag_in, b_mag;
  logic [32:0] rem_sh, diff;
  logic [63:0] a_ext, b_ext;
  logic [31:0] q_fix, r_fix;

  assign mul_req = start && (func == FUNC_MUL);
  assign div_req = start && (func == FUNC_DIV);
  assign accept  = (state == S_IDLE) && (mul_req || div_req) && !flush;

  assign stall = !flush && (accept || state == S_MUL || state == S_DIV);
  assign busy  = (state != S_IDLE);
  assign hi    = hi_r;
  assign lo    = lo_r;

  assign a_mag_in = (sign && src_a[31]) ? -src_a : src_a;
  assign b_mag    = (req.sgn && req.b[31]) ? -req.b : req.b;

  // Restoring step: shift next dividend bit (kept in quot_r MSB) into rem.
  assign rem_sh = {rem_r, quot_r[31]};
  assign diff   = rem_sh - {1'b0, b_mag};

  // Low 64 bits of the extended product are correct for both signednesses.
  assign a_ext = {{32{req.sgn & req.a[31]}}, req.a};
  assign b_ext = {{32{req.sgn & req.b[31]}}, req.b};

  assign q_fix = req.neg_q ? -quot_r : quot_r;
  assign r_fix = req.neg_r ? -rem_r  : rem_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      req    <= '0;
      cnt    <= '0;
      rem_r  <= '0;
      quot_r <= '0;
      prod_r <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      // MT writes first so a coinciding DONE write below overrides them.
      if (!stall && !flush) begin
        if (hi_write) hi_r <= hi_write_data;
        if (lo_write) lo_r <= lo_write_data;
      end
      if (flush) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: if (accept) begin
            req.a      <= src_a;
            req.b      <= src_b;
            req.sgn    <= sign;
            req.is_div <= div_req;
            req.div0   <= div_req && (src_b == '0);
            req.neg_q  <= sign && (src_a[31] ^ src_b[31]);
            req.neg_r  <= sign && src_a[31];
            cnt        <= '0;
            rem_r      <= '0;
            quot_r     <= a_mag_in;
            if (!div_req)          state <= S_MUL;
            else if (src_b == '0)  state <= S_DONE;
            else                   state <= S_DIV;
          end
          S_MUL: begin
            prod_r <= a_ext * b_ext;
            state  <= S_DONE;
          end
          S_DIV: begin
            if (!diff[32]) begin
              rem_r  <= diff[31:0];
              quot_r <= {quot_r[30:0], 1'b1};
            end else begin
              rem_r  <= rem_sh[31:0];
              quot_r <= {quot_r[30:0], 1'b0};
            end
            cnt <= cnt + 6'd1;
            if (cnt == 6'd31) state <= S_DONE;
          end
          S_DONE: begin
            if (req.div0) begin
              hi_r <= req.a;
              lo_r <= 32'hFFFF_FFFF;
            end else if (req.is_div) begin
              hi_r <= r_fix;
              lo_r <= q_fix;
            end else begin
              hi_r <= prod_r[63:32];
              lo_r <= prod_r[31:0];
            end
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;
  localparam logic [4:0] F_MUL = 5'h18;
  localparam logic [4:0] F_DIV = 5'h1A;

  logic        clk, rst, start, sign, flush, hi_write, lo_write;
  logic [4:0]  func;
  logic [31:0] src_a, src_b, hi_write_data, lo_write_data;
  logic        stall, busy;
  logic [31:0] hi, lo;

  mdu_ctrl #(.FUNC_MUL(F_MUL), .FUNC_DIV(F_DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .func(func), .sign(sign),
    .src_a(src_a), .src_b(src_b), .flush(flush),
    .hi_write(hi_write), .hi_write_data(hi_write_data),
    .lo_write(lo_write), .lo_write_data(lo_write_data),
    .stall(stall), .hi(hi), .lo(lo), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];
  logic done_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: a DONE cycle is busy with stall low; the cycle after it must
  // show the next expected {hi,lo}.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk); #3;
      if (done_prev) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL result: unexpected DONE hi=%h lo=%h expected none", hi, lo);
        end else begin
          e = exp_q.pop_front();
          chk("result_hi", hi, e[63:32]);
          chk("result_lo", lo, e[31:0]);
        end
      end
      done_prev = busy && !stall && !flush && !rst;
    end
  end

  // Drive one request, count stall cycles starting with the acceptance cycle.
  task automatic issue(input string nm, input logic [4:0] f, input logic s,
                       input logic [31:0] a, input logic [31:0] b,
                       input int exp_stall, input logic push, input logic [63:0] res);
    int n;
    @(negedge clk);
    start = 1'b1; func = f; sign = s; src_a = a; src_b = b;
    if (push) exp_q.push_back(res);
    #1;
    n = 0;
    while (stall && n < 200) begin
      n++;
      @(negedge clk);
      start = 1'b0;
      #1;
    end
    start = 1'b0;
    chk({nm, "_stall"}, 32'(n), 32'(exp_stall));
  endtask

  // Start a DIV and abort it at T+10 with flush or rst.
  task automatic abort_div(input logic use_rst);
    logic [31:0] h0, l0;
    h0 = hi; l0 = lo;
    @(negedge clk);
    start = 1'b1; func = F_DIV; sign = 1'b0; src_a = 32'd1000; src_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #1 chk("abort_pre_stall", {31'b0, stall}, 32'd1);
    if (use_rst) rst = 1'b1;
    else begin
      flush = 1'b1;
      hi_write = 1'b1; hi_write_data = 32'hDEAD_BEEF;
    end
    #1;
    chk("abort_now_stall", {31'b0, stall}, 32'd0);
    if (use_rst) begin
      chk("rst_async_hi", hi, 32'd0);
      chk("rst_async_lo", lo, 32'd0);
      chk("rst_async_busy", {31'b0, busy}, 32'd0);
    end
    @(negedge clk);
    flush = 1'b0; rst = 1'b0; hi_write = 1'b0;
    #1;
    chk("abort_stall", {31'b0, stall}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_hi", hi, use_rst ? 32'd0 : h0);
    chk("abort_lo", lo, use_rst ? 32'd0 : l0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; func = '0; sign = 1'b0; src_a = '0; src_b = '0;
    flush = 1'b0; hi_write = 1'b0; lo_write = 1'b0;
    hi_write_data = '0; lo_write_data = '0;
    #1;
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_stall", {31'b0, stall}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    issue("mul_u",     F_MUL, 1'b0, 32'hFFFF_FFFF, 32'd2,         2, 1'b1, 64'h0000_0001_FFFF_FFFE);
    issue("mul_s",     F_MUL, 1'b1, 32'hFFFF_FFFF, 32'd2,         2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    issue("mul_s_min", F_MUL, 1'b1, 32'h8000_0000, 32'h8000_0000, 2, 1'b1, 64'h4000_0000_0000_0000);
    issue("div_s",     F_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2,        33, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD);
    issue("div_u",     F_DIV, 1'b0, 32'd100,       32'd7,        33, 1'b1, 64'h0000_0002_0000_000E);
    issue("div_s_nb",  F_DIV, 1'b1, 32'd7,         32'hFFFF_FFFE,33, 1'b1, 64'h0000_0001_FFFF_FFFD);
    issue("div_u_max", F_DIV, 1'b0, 32'hFFFF_FFFF, 32'd2,        33, 1'b1, 64'h0000_0001_7FFF_FFFF);
    issue("div_s_ovf", F_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,33, 1'b1, 64'h0000_0000_8000_0000);
    issue("div0_u",    F_DIV, 1'b0, 32'h1234_5678, 32'd0,         1, 1'b1, 64'h1234_5678_FFFF_FFFF);
    issue("div0_s",    F_DIV, 1'b1, 32'h8000_0000, 32'd0,         1, 1'b1, 64'h8000_0000_FFFF_FFFF);
    issue("noreq",     5'h03, 1'b0, 32'd5,         32'd5,         0, 1'b0, 64'd0);
    #1 chk("noreq_busy", {31'b0, busy}, 32'd0);

    // Back-to-back MUL then DIV
    issue("b2b_mul",   F_MUL, 1'b0, 32'd6,  32'd7,  2, 1'b1, 64'h0000_0000_0000_002A);
    issue("b2b_div",   F_DIV, 1'b0, 32'd42, 32'd5, 33, 1'b1, 64'h0000_0002_0000_0008);

    // MTHI held through a MUL: ignored while stalled, loses to DONE, then lands
    hi_write = 1'b1; hi_write_data = 32'hA5A5_A5A5;
    issue("mt_mul",    F_MUL, 1'b0, 32'd3, 32'd5, 2, 1'b1, 64'h0000_0000_0000_000F);
    @(negedge clk);
    @(negedge clk);
    hi_write = 1'b0;
    #1;
    chk("mthi_hi", hi, 32'hA5A5_A5A5);
    chk("mthi_lo", lo, 32'd15);
    lo_write = 1'b1; lo_write_data = 32'h11;
    @(negedge clk);
    lo_write = 1'b0;
    #1;
    chk("mtlo_lo", lo, 32'h11);
    chk("mtlo_hi", hi, 32'hA5A5_A5A5);

    abort_div(1'b0);
    abort_div(1'b1);

    issue("post_rst",  F_MUL, 1'b0, 32'h0001_0000, 32'h0001_0000, 2, 1'b1, 64'h0000_0001_0000_0000);

    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Port list SHALL be as follows (clock and reset first):
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: EX-stage request for a multiply or divide; held with operands stable while `stall`=1.
- `func` input 5: operation code; only `FUNC_MUL` and `FUNC_DIV` start work, any other value means no request.
- `sign` input 1: 1 = signed operation, 0 = unsigned.
- `src_a` input 32: multiplicand or dividend.
- `src_b` input 32: multiplier or divisor.
- `flush` input 1: exception or cancel; aborts the operation in flight.
- `hi_write` input 1: MTHI write enable.
- `hi_write_data` input 32: MTHI data.
- `lo_write` input 1: MTLO write enable.
- `lo_write_data` input 32: MTLO data.
- `stall` output 1: holds the pipeline while an operation is in progress.
- `hi` output 32: architectural HI register.
- `lo` output 32: architectural LO register.
- `busy` output 1: 1 whenever state is not IDLE.

Function
REQ-002 The FSM SHALL have states IDLE, MUL, DIV and DONE, plus a 6-bit iteration counter `cnt`.
REQ-003 A request is accepted when state=IDLE, `start`=1, `func` is MUL or DIV, and `flush`=0.
- `src_a`, `src_b`, `sign` and the operation SHALL be captured into internal registers on that edge.
REQ-004 IDLE transitions SHALL be:
- MUL request → MUL.
- DIV request with `src_b`≠0 → DIV, with `cnt`=0.
- DIV request with `src_b`=0 → DONE.
- Otherwise stay in IDLE.
REQ-005 In MUL the full 64-bit product SHALL be registered (signed or unsigned per the captured `sign`); the next state is DONE.
REQ-006 DIV SHALL run a restoring divide on operand magnitudes, one quotient bit per cycle, for exactly 32 cycles (`cnt` 0..31); after the cycle with `cnt`=31 the next state is DONE.
REQ-007 Signed divide results SHALL be sign-corrected as follows:
- Quotient is negated when sign(a)≠sign(b).
- Remainder takes the sign of the dividend.
REQ-008 Divide by zero SHALL produce HI=captured `src_a` and LO=32'hFFFFFFFF, for both signed and unsigned operations.
REQ-009 Results SHALL map to the registers as follows:
- MUL: HI=product[63:32], LO=product[31:0].
- DIV: HI=remainder, LO=quotient.
REQ-010 HI and LO SHALL be written on the edge ending the DONE cycle; the next state is then IDLE.
REQ-011 `stall` SHALL be combinational:
- 1 in IDLE when a request is accepted.
- 1 throughout MUL and DIV.
- 0 in DONE and whenever `flush`=1.
REQ-012 Latency from the acceptance cycle T SHALL be:
- MUL: `stall`=1 in T and T+1; DONE in T+2; new HI/LO visible in T+3.
- DIV: `stall`=1 in T..T+32; DONE in T+33.
- Divide by zero: `stall`=1 in T; DONE in T+1.
REQ-013 A request present in the cycle immediately after DONE SHALL be treated as a new instruction and accepted normally (back-to-back operations allowed).
REQ-014 `flush`=1 in any state SHALL force IDLE on the next edge.
- No HI/LO write from the aborted operation.
- `hi_write`/`lo_write` in that cycle are ignored.
REQ-015 MTHI/MTLO writes SHALL be applied only when `stall`=0 and `flush`=0.
- `hi_write` and `lo_write` act independently.
- If a DONE write and an MT write coincide, the DONE result wins.
REQ-016 `hi` and `lo` SHALL reflect register contents only; there is no combinational bypass.

Reset
REQ-017 Asserting `rst` SHALL immediately force the following, regardless of the clock and including mid-operation:
- state=IDLE, `cnt`=0.
- `hi`=0, `lo`=0.
- `stall`=0, `busy`=0.
- All operand and partial-result registers cleared.
REQ-018 After `rst` deasserts, the first accepted request SHALL behave identically to one issued after a normal idle period.

Verification
REQ-019 Unsigned MUL: `src_a`=32'hFFFFFFFF, `src_b`=2 → `stall`=1 for 2 cycles; then HI=32'h00000001, LO=32'hFFFFFFFE.
REQ-020 Signed MUL: `src_a`=32'hFFFFFFFF, `src_b`=2 → HI=32'hFFFFFFFF, LO=32'hFFFFFFFE.
REQ-021 Signed DIV: `src_a`=-7, `src_b`=2 → `stall`=1 for exactly 33 cycles; then LO=32'hFFFFFFFD, HI=32'hFFFFFFFF. Repeat unsigned with 100/7 → LO=14, HI=2.
REQ-022 DIV by zero: `src_a`=32'h12345678, `src_b`=0 → `stall`=1 for 1 cycle; then HI=32'h12345678, LO=32'hFFFFFFFF.
REQ-023 Abort during DIV: assert `flush` at cycle T+10, or `rst` at T+10 in a separate run →
- Next cycle state is IDLE and `stall`=0.
- With `flush`: HI/LO unchanged.
- With `rst`: HI/LO=0.
REQ-024 MT priority and back-to-back:
- MTHI with 32'hA5A5A5A5 while `stall`=1 is ignored; after `stall` drops it writes.
- MUL immediately followed by DIV is accepted in the cycle after DONE; both results are correct.
